// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding control for the five-stage MIPS pipeline.
// Drives stage stall/bubble controls, ID/EX forwarding selects and tracks HI/LO busy time.
module hazard_forward_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MD_LATENCY  = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  ID_Rs,
    input  logic [REG_ADDR_W-1:0]  ID_Rt,
    input  logic                   ID_RsRead,
    input  logic                   ID_RtRead,
    input  logic                   ID_Branch,
    input  logic [REG_ADDR_W-1:0]  EX_Rs,
    input  logic [REG_ADDR_W-1:0]  EX_Rt,
    input  logic                   EX_RsRead,
    input  logic                   EX_RtRead,
    input  logic [REG_ADDR_W-1:0]  EX_RegDst,
    input  logic                   EX_RegWrite,
    input  logic                   EX_MemRead,
    input  logic [REG_ADDR_W-1:0]  MEM_RegDst,
    input  logic                   MEM_RegWrite,
    input  logic                   MEM_MemRead,
    input  logic [REG_ADDR_W-1:0]  WB_RegDst,
    input  logic                   WB_RegWrite,
    input  logic                   EX_MD_Start,
    input  logic                   EX_MD_Read,
    input  logic                   EX_ALU_Stall,
    output logic                   IF_Stall,
    output logic                   ID_Stall,
    output logic                   EX_Stall,
    output logic                   EX_Bubble,
    output logic                   MEM_Bubble,
    output logic [1:0]             ID_RsFwdSel,
    output logic [1:0]             ID_RtFwdSel,
    output logic [1:0]             EX_RsFwdSel,
    output logic [1:0]             EX_RtFwdSel,
    output logic                   MD_Busy,
    output logic [STALL_CNT_W-1:0] STALL_CNT
);

    localparam int MD_W = $clog2(MD_LATENCY + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY);

    // A producer hits when it writes a nonzero register that the consumer actually reads.
    function automatic logic hit(
        input logic                  wr,
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  rd
    );
        return wr & (dst != '0) & (dst == src) & rd;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit)
            return 2'd1;
        else if (wb_hit)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    logic id_rs_ex, id_rt_ex;
    logic id_rs_mem, id_rt_mem;
    logic id_rs_wb, id_rt_wb;
    logic ex_rs_mem, ex_rt_mem;
    logic ex_rs_wb, ex_rt_wb;

    assign id_rs_ex  = hit(EX_RegWrite,  EX_RegDst,  ID_Rs, ID_RsRead);
    assign id_rt_ex  = hit(EX_RegWrite,  EX_RegDst,  ID_Rt, ID_RtRead);
    assign id_rs_mem = hit(MEM_RegWrite, MEM_RegDst, ID_Rs, ID_RsRead);
    assign id_rt_mem = hit(MEM_RegWrite, MEM_RegDst, ID_Rt, ID_RtRead);
    assign id_rs_wb  = hit(WB_RegWrite,  WB_RegDst,  ID_Rs, ID_RsRead);
    assign id_rt_wb  = hit(WB_RegWrite,  WB_RegDst,  ID_Rt, ID_RtRead);
    assign ex_rs_mem = hit(MEM_RegWrite, MEM_RegDst, EX_Rs, EX_RsRead);
    assign ex_rt_mem = hit(MEM_RegWrite, MEM_RegDst, EX_Rt, EX_RtRead);
    assign ex_rs_wb  = hit(WB_RegWrite,  WB_RegDst,  EX_Rs, EX_RsRead);
    assign ex_rt_wb  = hit(WB_RegWrite,  WB_RegDst,  EX_Rt, EX_RtRead);

    // ID selects still report a MEM load hit; the branch stall keeps it from being consumed.
    assign ID_RsFwdSel = fwd_sel(id_rs_mem, id_rs_wb);
    assign ID_RtFwdSel = fwd_sel(id_rt_mem, id_rt_wb);
    assign EX_RsFwdSel = fwd_sel(ex_rs_mem, ex_rs_wb);
    assign EX_RtFwdSel = fwd_sel(ex_rt_mem, ex_rt_wb);

    logic [MD_W-1:0]        md_cnt_q, md_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   md_busy;
    logic                   md_stall;
    logic                   ex_hold;
    logic                   load_use;
    logic                   branch_haz;
    logic                   id_hold;

    assign md_busy    = (md_cnt_q != '0);
    assign md_stall   = md_busy & (EX_MD_Read | EX_MD_Start);
    assign ex_hold    = EX_ALU_Stall | md_stall;
    assign load_use   = EX_MemRead & (id_rs_ex | id_rt_ex);
    assign branch_haz = ID_Branch &
                        ((id_rs_ex | id_rt_ex) | (MEM_MemRead & (id_rs_mem | id_rt_mem)));
    assign id_hold    = load_use | branch_haz;

    assign EX_Stall   = ex_hold;
    assign ID_Stall   = ex_hold | id_hold;
    assign IF_Stall   = ex_hold | id_hold;
    assign MEM_Bubble = ex_hold;
    assign EX_Bubble  = id_hold & ~ex_hold;
    assign MD_Busy    = md_busy;
    assign STALL_CNT  = stall_cnt_q;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (EX_MD_Start && !md_busy && !ex_hold)
            md_cnt_d = MD_LOAD;
        else if (md_busy)
            md_cnt_d = md_cnt_q - MD_W'(1);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (IF_Stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
